// File: rtl/line_pixel_scanner.sv
// line_pixel_scanner
//
// Initiator-side driver for the per-pixel line/arrow hit-test checker.
// It accepts one arrow command: origin, unit direction and magnitude, all
// in Q16.16. From that it builds a padded pixel bounding box and clamps the
// box to the screen. It then walks the box in raster order. For each pixel
// it pulses the checker's start and waits for the checker's result-valid.
// Every hit becomes one framebuffer write.
//
// Optional feature (macro SCAN_STATS_EN): adds the hit_count and scan_count
// outputs. Both are saturating 16-bit counters, cleared on command accept.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; the command is sampled on accept
//   x0,y0,xn,yn,mag     arrow command fields, Q16.16 signed
//   chk_x, chk_y        current pixel as Q16.16 ({p,16'b0})
//   chk_x0..chk_mag     latched command fields forwarded to the checker
//   chk_start           one-cycle start pulse to the checker
//   chk_on_line,chk_we  checker hit result and result-valid pulse
//   fb_we, fb_addr      framebuffer write strobe and address (py*SCREEN_W+px)
//   busy, done          scan in progress; one-cycle end-of-scan pulse
//   hit_count,scan_count (SCAN_STATS_EN only) writes issued, pixels checked
module line_pixel_scanner #(
    parameter int SCREEN_W   = 64,
    parameter int SCREEN_H   = 48,
    parameter int LINE_WIDTH = 5,
    parameter int ADDR_W     = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic signed [31:0]  x0,
    input  logic signed [31:0]  y0,
    input  logic signed [31:0]  xn,
    input  logic signed [31:0]  yn,
    input  logic signed [31:0]  mag,
    output logic signed [31:0]  chk_x,
    output logic signed [31:0]  chk_y,
    output logic signed [31:0]  chk_x0,
    output logic signed [31:0]  chk_y0,
    output logic signed [31:0]  chk_xn,
    output logic signed [31:0]  chk_yn,
    output logic signed [31:0]  chk_mag,
    output logic                chk_start,
    input  logic                chk_on_line,
    input  logic                chk_we,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic                busy,
    output logic                done
`ifdef SCAN_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         scan_count
`endif
);

    typedef enum logic [3:0] {
        S_DRAIN,
        S_IDLE,
        S_BBOX,
        S_CLAMP,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]         drain_cnt;
    logic signed [31:0] bb_xlo, bb_xhi, bb_ylo, bb_yhi;   // unclamped box
    logic [15:0]        xlo, xhi, ylo, yhi;               // clamped box
    logic [15:0]        px, py;

    // Bounding-box arithmetic
    logic signed [63:0] prod_x, prod_y;
    logic signed [31:0] x1, y1, xmin, xmax, ymin, ymax;
    logic signed [31:0] box_xlo, box_xhi, box_ylo, box_yhi;

    // Clamp stage
    logic               offscreen;
    logic [15:0]        cx_lo, cx_hi, cy_lo, cy_hi;

    assign chk_x = {px, 16'b0};
    assign chk_y = {py, 16'b0};

    always_comb begin
        prod_x  = $signed({{32{chk_xn[31]}}, chk_xn}) * $signed({{32{chk_mag[31]}}, chk_mag});
        prod_y  = $signed({{32{chk_yn[31]}}, chk_yn}) * $signed({{32{chk_mag[31]}}, chk_mag});
        // Truncating (prod >>> 16) to 32 bits selects product bits [47:16].
        x1      = chk_x0 + 32'(prod_x >>> 16);
        y1      = chk_y0 + 32'(prod_y >>> 16);
        xmin    = (chk_x0 < x1) ? chk_x0 : x1;
        xmax    = (chk_x0 < x1) ? x1 : chk_x0;
        ymin    = (chk_y0 < y1) ? chk_y0 : y1;
        ymax    = (chk_y0 < y1) ? y1 : chk_y0;
        // Arithmetic shift floors negative coordinates toward -inf.
        box_xlo = (xmin >>> 16) - LINE_WIDTH;
        box_xhi = (xmax >>> 16) + LINE_WIDTH;
        box_ylo = (ymin >>> 16) - LINE_WIDTH;
        box_yhi = (ymax >>> 16) + LINE_WIDTH;
    end

    always_comb begin
        offscreen = (bb_xhi < 0) || (bb_xlo > SCREEN_W - 1) ||
                    (bb_yhi < 0) || (bb_ylo > SCREEN_H - 1);
        cx_lo = (bb_xlo < 0) ? 16'd0 : (bb_xlo > SCREEN_W - 1) ? 16'(SCREEN_W - 1) : bb_xlo[15:0];
        cx_hi = (bb_xhi < 0) ? 16'd0 : (bb_xhi > SCREEN_W - 1) ? 16'(SCREEN_W - 1) : bb_xhi[15:0];
        cy_lo = (bb_ylo < 0) ? 16'd0 : (bb_ylo > SCREEN_H - 1) ? 16'(SCREEN_H - 1) : bb_ylo[15:0];
        cy_hi = (bb_yhi < 0) ? 16'd0 : (bb_yhi > SCREEN_H - 1) ? 16'(SCREEN_H - 1) : bb_yhi[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_DRAIN;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        chk_start = 1'b0;
        fb_we     = 1'b0;
        done      = 1'b0;
        case (state)
            // The checker has no reset; give any in-flight operation time to retire.
            S_DRAIN: if (drain_cnt == 2'd3) state_n = S_IDLE;
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_n = S_BBOX;
            end
            S_BBOX:  state_n = S_CLAMP;
            S_CLAMP: state_n = offscreen ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                chk_start = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: if (chk_we) state_n = chk_on_line ? S_WRITE : S_NEXT;
            S_WRITE: begin
                fb_we   = 1'b1;
                state_n = S_NEXT;
            end
            S_NEXT: begin
                if (px < xhi || py < yhi) state_n = S_ISSUE;
                else                      state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
            chk_x0    <= '0;
            chk_y0    <= '0;
            chk_xn    <= '0;
            chk_yn    <= '0;
            chk_mag   <= '0;
            busy      <= 1'b0;
            bb_xlo    <= '0;
            bb_xhi    <= '0;
            bb_ylo    <= '0;
            bb_yhi    <= '0;
            xlo       <= '0;
            xhi       <= '0;
            ylo       <= '0;
            yhi       <= '0;
            px        <= '0;
            py        <= '0;
            fb_addr   <= '0;
`ifdef SCAN_STATS_EN
            hit_count  <= '0;
            scan_count <= '0;
`endif
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    chk_x0  <= x0;
                    chk_y0  <= y0;
                    chk_xn  <= xn;
                    chk_yn  <= yn;
                    chk_mag <= mag;
                    busy    <= 1'b1;
`ifdef SCAN_STATS_EN
                    hit_count  <= '0;
                    scan_count <= '0;
`endif
                end
                S_BBOX: begin
                    bb_xlo <= box_xlo;
                    bb_xhi <= box_xhi;
                    bb_ylo <= box_ylo;
                    bb_yhi <= box_yhi;
                end
                S_CLAMP: begin
                    xlo <= cx_lo;
                    xhi <= cx_hi;
                    ylo <= cy_lo;
                    yhi <= cy_hi;
                    px  <= cx_lo;
                    py  <= cy_lo;
                end
`ifdef SCAN_STATS_EN
                S_ISSUE: if (scan_count != 16'hFFFF) scan_count <= scan_count + 16'd1;
`endif
                S_WAIT: if (chk_we && chk_on_line)
                    fb_addr <= ADDR_W'(32'(py) * SCREEN_W + 32'(px));
`ifdef SCAN_STATS_EN
                S_WRITE: if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
                S_NEXT: begin
                    if (px < xhi) begin
                        px <= px + 16'd1;
                    end else if (py < yhi) begin
                        px <= xlo;
                        py <= py + 16'd1;
                    end
                end
                S_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/line_pixel_scanner.md
Name: line_pixel_scanner

Overview:
- Initiator-side driver for the per-pixel line/arrow hit-test checker.
- Accepts one arrow command: origin, unit direction and magnitude, all Q16.16. Computes a clamped pixel bounding box.
- Walks every pixel in the box in raster order. For each pixel it pulses the checker's start, waits for the checker's write-enable, and on a hit issues a framebuffer write.
- Sits between the arrow/vector-field sequencer (command side) and the framebuffer (write side).

Parameters:
- SCREEN_W, 64, framebuffer width in pixels
- SCREEN_H, 48, framebuffer height in pixels
- LINE_WIDTH, 5, integer pixel half-width used to pad the bounding box; must match the checker's LINE_WIDTH
- ADDR_W, 12, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- x0, y0  in  32 signed  arrow origin, Q16.16
- xn, yn  in  32 signed  unit direction, Q16.16
- mag  in  32 signed  arrow length, Q16.16, >= 0
- chk_x, chk_y  out  32 signed  current pixel as Q16.16 ({p,16'b0})
- chk_x0, chk_y0, chk_xn, chk_yn, chk_mag  out  32 signed  latched command fields forwarded to the checker
- chk_start  out  1  one-cycle start pulse to the checker
- chk_on_line  in  1  checker hit result
- chk_we  in  1  checker result-valid pulse
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  ADDR_W  py*SCREEN_W+px
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at end of scan

Behaviour:
- Reset (async): all outputs 0 except cmd_ready; state DRAIN.
- DRAIN:
  - 4-cycle counter; cmd_ready=0 throughout.
  - The checker has no reset, so this lets any in-flight checker op retire.
  - Then go to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch x0..mag into the chk_* registers; busy<=1; go to BBOX.
  - chk_we is ignored in every state except WAIT.
- BBOX (1 cycle):
  - x1 = x0 + (xn*mag)[47:16] and y1 = y0 + (yn*mag)[47:16], using 64-bit signed products.
  - xlo = min(x0,x1)>>>16 minus LINE_WIDTH; xhi = max(x0,x1)>>>16 plus LINE_WIDTH. Same for y.
  - Arithmetic shift, i.e. floor.
- CLAMP (1 cycle):
  - Clamp x to [0,SCREEN_W-1] and y to [0,SCREEN_H-1].
  - If the unclamped xhi<0, xlo>SCREEN_W-1, yhi<0 or ylo>SCREEN_H-1, go to DONE with no checker traffic.
  - Otherwise px=xlo, py=ylo; go to ISSUE.
- ISSUE (1 cycle): chk_start=1; chk_x/chk_y already hold px/py; go to WAIT.
- WAIT:
  - chk_x/chk_y are held stable.
  - On chk_we: if chk_on_line, then fb_we=1 and fb_addr=py*SCREEN_W+px in the next cycle (WRITE); go to NEXT.
  - The nominal checker latency is chk_we 4 cycles after chk_start; the block must not depend on that exact value.
- NEXT:
  - If px<xhi: px++.
  - Else if py<yhi: px=xlo, py++.
  - Else go to DONE. Otherwise go to ISSUE.
- DONE: done=1 for one cycle; busy<=0; go to IDLE.
- Rules:
  - Exactly one chk_start per pixel.
  - No chk_start while awaiting chk_we.
  - fb_we is at most one per pixel, in raster order.
  - The command is not re-read during a scan; cmd_valid during busy is held off by cmd_ready=0.
- mag=0 is legal: the box is the padded point.
- Reset mid-scan: abort immediately with no further fb_we; go through DRAIN.

Optional Feature:
- SCAN_STATS_EN defined:
  - Adds output hit_count (16 bits) and output scan_count (16 bits).
  - Both are cleared on command accept.
  - hit_count increments per fb_we; scan_count increments per chk_start.
  - Both saturate at 16'hFFFF, hold after done, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Horizontal arrow, x0=10.0, y0=20.0, xn=1.0, yn=0, mag=20.0 (behavioural checker model, 4-cycle latency):
  - box x 5..35, y 15..25;
  - exactly 341 chk_start pulses;
  - fb_we at addr 1290 (10,20), 1310 (30,20) and 1286 (6,20) absent;
  - one done pulse.
- Fully offscreen, x0=-100.0, y0=10.0, xn=1.0, mag=10.0: no chk_start, no fb_we, done within 4 cycles of accept.
- Right-edge clamp, x0=60.0, y0=5.0, xn=1.0, mag=20.0:
  - px never exceeds 63;
  - first chk_x=55.0, last chk_x=63.0;
  - no fb_addr outside 0..3071.
- Variable checker latency of 4, 7, then 12 cycles: chk_x stable across each WAIT, no duplicate chk_start, identical fb_we set to the 4-cycle run.
- Spurious chk_we pulsed while in IDLE and DRAIN: no fb_we, no state change.
- rst asserted during WAIT of the 3rd pixel:
  - outputs 0 in the same cycle;
  - cmd_ready stays 0 for 4 cycles after release, then 1;
  - a new command scans correctly.
  - With SCAN_STATS_EN, the horizontal-arrow case gives scan_count=341 and hit_count equal to the model hit count.
